// File: rtl/sysid_regbank.sv
// sysid_regbank: system identification register bank.
// Eight 32-bit words: fixed ID and build timestamp, a free-running uptime
// counter with a coherent high-word shadow, a control word and up to three
// scratch words. Reads are fully pipelined with a fixed READ_LATENCY.
//
// Legal parameter ranges: UPTIME_WIDTH 33..64, READ_LATENCY 1..4,
// NUM_SCRATCH 0..3.
module sysid_regbank #(
   parameter logic [31:0] SYSTEM_ID    = 32'h56DC_3F2D,
   parameter logic [31:0] TIMESTAMP    = 32'h0,
   parameter int unsigned UPTIME_WIDTH = 48,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned NUM_SCRATCH  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   localparam int unsigned HI_W   = UPTIME_WIDTH - 32;
   localparam int unsigned SCR_N  = 3;
   localparam logic [2:0]  A_ID   = 3'd0;
   localparam logic [2:0]  A_TS   = 3'd1;
   localparam logic [2:0]  A_UPLO = 3'd2;
   localparam logic [2:0]  A_UPHI = 3'd3;
   localparam logic [2:0]  A_CTRL = 3'd4;
   localparam logic [2:0]  A_SCR0 = 3'd5;

   // architectural state
   logic [UPTIME_WIDTH-1:0] cnt_q, cnt_d;
   logic [HI_W-1:0]         shadow_q, shadow_d;
   logic                    run_q, run_d;
   logic                    wrap_q, wrap_d;
   logic [31:0]             scratch_q [SCR_N];
   logic [31:0]             scratch_d [SCR_N];

   // read return pipeline; stage READ_LATENCY-1 drives the outputs
   logic                    pipe_vld_q  [READ_LATENCY];
   logic [31:0]             pipe_data_q [READ_LATENCY];

   logic                    wr_acc_c;
   logic                    ctrl_wr_c;
   logic                    clear_c;
   logic                    cnt_max_c;
   logic                    wrap_set_c;
   logic [31:0]             rd_word_c;

   // Write decode: a read in the same cycle wins and the write is dropped.
   always_comb begin
      wr_acc_c  = write & ~read;
      ctrl_wr_c = wr_acc_c & (address == A_CTRL);
      clear_c   = ctrl_wr_c & writedata[1];
   end

   // Read word mux, sampled in the accept cycle.
   always_comb begin
      rd_word_c = '0;
      case (address)
         A_ID:    rd_word_c = SYSTEM_ID;
         A_TS:    rd_word_c = TIMESTAMP;
         A_UPLO:  rd_word_c = cnt_q[31:0];
         A_UPHI:  rd_word_c = 32'(shadow_q);
         A_CTRL:  rd_word_c = {29'd0, wrap_q, 1'b0, run_q};
         default: begin
            for (int unsigned i = 0; i < SCR_N; i++) begin
               if ((i < NUM_SCRATCH) && (address == 3'(32'(A_SCR0) + i))) begin
                  rd_word_c = scratch_q[i];
               end
            end
         end
      endcase
   end

   // Next-state for counter, shadow, CTRL bits and scratch words.
   always_comb begin
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      run_d      = run_q;
      wrap_set_c = 1'b0;
      scratch_d  = scratch_q;
      cnt_max_c  = (cnt_q == '1);

      // clear beats both increment and the wrap it would have caused
      if (clear_c) begin
         cnt_d = '0;
      end else if (run_q) begin
         if (cnt_max_c) begin
            cnt_d      = '0;
            wrap_set_c = 1'b1;
         end else begin
            cnt_d = cnt_q + UPTIME_WIDTH'(1);
         end
      end

      // a clear command leaves run untouched so the counter can be zeroed
      // without stopping it
      if (ctrl_wr_c && !writedata[1]) begin
         run_d = writedata[0];
      end

      // a wrap arriving in the same cycle as its W1C keeps the flag set
      wrap_d = wrap_set_c | (wrap_q & ~(ctrl_wr_c & writedata[2]));

      // snapshot the high part together with the low-word read
      if (read && (address == A_UPLO)) begin
         shadow_d = cnt_q[UPTIME_WIDTH-1:32];
      end

      for (int unsigned i = 0; i < SCR_N; i++) begin
         if (wr_acc_c && (i < NUM_SCRATCH) && (address == 3'(32'(A_SCR0) + i))) begin
            scratch_d[i] = writedata;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         run_q    <= 1'b1;
         wrap_q   <= 1'b0;
         for (int unsigned i = 0; i < SCR_N; i++) begin
            scratch_q[i] <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         run_q    <= run_d;
         wrap_q   <= wrap_d;
         for (int unsigned i = 0; i < SCR_N; i++) begin
            scratch_q[i] <= scratch_d[i];
         end
      end
   end

   // Read return pipeline; data is zero in every idle slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            pipe_vld_q[i]  <= 1'b0;
            pipe_data_q[i] <= '0;
         end
      end else begin
         pipe_vld_q[0]  <= read;
         pipe_data_q[0] <= read ? rd_word_c : 32'd0;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
         end
      end
   end

   assign readdata      = pipe_data_q[READ_LATENCY-1];
   assign readdatavalid = pipe_vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regbank.sv
// Bench for sysid_regbank: two instances with different parameter sets,
// directed scenarios followed by random traffic, all checked every cycle
// against a transaction-level model of the register map.
module tb_sysid_regbank;

   localparam logic [31:0] SID0 = 32'h56DC_3F2D;
   localparam logic [31:0] TS0  = 32'h6520_1A3C;
   localparam logic [31:0] SID1 = 32'hA5A5_0F0F;
   localparam logic [31:0] TS1  = 32'h1234_5678;
   localparam int unsigned UW0 = 48, RL0 = 3, NS0 = 1;
   localparam int unsigned UW1 = 33, RL1 = 4, NS1 = 3;

   logic        clk = 1'b0;
   logic        rst   [2];
   logic        rd    [2];
   logic        wr    [2];
   logic [2:0]  addr  [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];
   logic        rdv   [2];

   always #5 clk = ~clk;

   sysid_regbank #(
      .SYSTEM_ID(SID0), .TIMESTAMP(TS0), .UPTIME_WIDTH(UW0),
      .READ_LATENCY(RL0), .NUM_SCRATCH(NS0)
   ) dut0 (
      .clock(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]),
      .write(wr[0]), .writedata(wd[0]), .readdata(rdata[0]),
      .readdatavalid(rdv[0])
   );

   sysid_regbank #(
      .SYSTEM_ID(SID1), .TIMESTAMP(TS1), .UPTIME_WIDTH(UW1),
      .READ_LATENCY(RL1), .NUM_SCRATCH(NS1)
   ) dut1 (
      .clock(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]),
      .write(wr[1]), .writedata(wd[1]), .readdata(rdata[1]),
      .readdatavalid(rdv[1])
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          chk_en   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned due;
      logic [31:0] data;
   } rd_t;

   longint unsigned m_cnt    [2];
   longint unsigned m_shadow [2];
   bit              m_run    [2];
   bit              m_wrap   [2];
   logic [31:0]     m_scr    [2][3];
   rd_t             pend0 [$];
   rd_t             pend1 [$];
   bit              exp_rdv   [2];
   logic [31:0]     exp_rdata [2];
   int unsigned     cyc = 0;

   function automatic int unsigned uw(input int d);
      return (d == 0) ? UW0 : UW1;
   endfunction

   function automatic int unsigned rl(input int d);
      return (d == 0) ? RL0 : RL1;
   endfunction

   function automatic int unsigned ns(input int d);
      return (d == 0) ? NS0 : NS1;
   endfunction

   function automatic logic [31:0] word_val(input int d, input logic [2:0] a);
      int unsigned idx;
      case (a)
         3'd0:    return (d == 0) ? SID0 : SID1;
         3'd1:    return (d == 0) ? TS0 : TS1;
         3'd2:    return 32'(m_cnt[d]);
         3'd3:    return 32'(m_shadow[d]);
         3'd4:    return {29'd0, m_wrap[d], 1'b0, m_run[d]};
         default: begin
            idx = 32'(a) - 5;
            return (idx < ns(d)) ? m_scr[d][idx] : 32'd0;
         end
      endcase
   endfunction

   task automatic model_step(input int d);
      rd_t             e;
      longint unsigned nxt;
      bit              wset;
      bit              wacc;
      bit              ctrl_w;
      int unsigned     idx;
      if (rst[d]) begin
         m_cnt[d] = 0; m_shadow[d] = 0; m_run[d] = 1'b1; m_wrap[d] = 1'b0;
         for (int i = 0; i < 3; i++) m_scr[d][i] = 32'd0;
         if (d == 0) pend0.delete(); else pend1.delete();
         exp_rdv[d] = 1'b0; exp_rdata[d] = 32'd0;
         return;
      end
      wset   = 1'b0;
      wacc   = !rd[d] && wr[d];
      ctrl_w = wacc && (addr[d] == 3'd4);
      if (rd[d]) begin
         e.due  = cyc + rl(d) - 1;
         e.data = word_val(d, addr[d]);
         if (d == 0) pend0.push_back(e); else pend1.push_back(e);
         if (addr[d] == 3'd2) m_shadow[d] = m_cnt[d] >> 32;
      end
      if (ctrl_w && wd[d][1]) begin
         m_cnt[d] = 0;
      end else if (m_run[d]) begin
         nxt = m_cnt[d] + 1;
         if (nxt == (64'd1 << uw(d))) begin
            nxt  = 0;
            wset = 1'b1;
         end
         m_cnt[d] = nxt;
      end
      if (ctrl_w) begin
         if (wd[d][2]) m_wrap[d] = 1'b0;
         if (!wd[d][1]) m_run[d] = wd[d][0];
      end
      if (wset) m_wrap[d] = 1'b1;
      if (wacc && addr[d] >= 3'd5) begin
         idx = 32'(addr[d]) - 5;
         if (idx < ns(d)) m_scr[d][idx] = wd[d];
      end
      exp_rdv[d]   = 1'b0;
      exp_rdata[d] = 32'd0;
      if (d == 0) begin
         if (pend0.size() > 0 && pend0[0].due == cyc) begin
            e = pend0.pop_front(); exp_rdv[d] = 1'b1; exp_rdata[d] = e.data;
         end
      end else begin
         if (pend1.size() > 0 && pend1[0].due == cyc) begin
            e = pend1.pop_front(); exp_rdv[d] = 1'b1; exp_rdata[d] = e.data;
         end
      end
   endtask

   // advance the model on every rising edge
   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
   end

   // compare both instances against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check("rdv0",   32'(rdv[0]), 32'(exp_rdv[0]));
         check("rdata0", rdata[0],    exp_rdata[0]);
         check("rdv1",   32'(rdv[1]), 32'(exp_rdv[1]));
         check("rdata1", rdata[1],    exp_rdata[1]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic deposit(input int d, input longint unsigned v);
      if (d == 0) dut0.cnt_q <= 48'(v);
      else        dut1.cnt_q <= 33'(v);
      m_cnt[d] = v;
   endtask

   task automatic rd_word(input int d, input logic [2:0] a,
                          output logic [31:0] data, output int lat);
      rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = a;
      @(negedge clk);
      rd[d] = 1'b0;
      lat  = 0;
      data = 32'd0;
      for (int i = 1; i <= 8; i++) begin
         if (rdv[d]) begin
            lat  = i;
            data = rdata[d];
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wr_word(input int d, input logic [2:0] a, input logic [31:0] v);
      wr[d] = 1'b1; rd[d] = 1'b0; addr[d] = a; wd[d] = v;
      @(negedge clk);
      wr[d] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0]     data;
      int              lat;
      longint unsigned max1;
      max1 = (64'd1 << UW1) - 1;

      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 3'd0; wd[d] = 32'd0;
      end
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_rdv0",   32'(rdv[0]), 32'd0);
      check("rst_rdata0", rdata[0],    32'd0);
      check("rst_rdv1",   32'(rdv[1]), 32'd0);
      check("rst_rdata1", rdata[1],    32'd0);

      // first read after reset release sees the counter before its first tick
      rst[0] = 1'b0; rst[1] = 1'b0;
      rd_word(0, 3'd2, data, lat);
      check("uplo_first", data, 32'd0);

      // ID, timestamp and latency
      rd_word(0, 3'd0, data, lat);
      check("id0", data, SID0);
      check("lat0", 32'(lat), 32'(RL0));
      rd_word(0, 3'd1, data, lat);
      check("ts0", data, TS0);
      rd_word(1, 3'd0, data, lat);
      check("id1", data, SID1);
      check("lat1", 32'(lat), 32'(RL1));
      rd_word(1, 3'd1, data, lat);
      check("ts1", data, TS1);

      // LO/HI coherency across a 32-bit carry
      deposit(0, 64'h0000_0000_FFFF_FFFF);
      rd_word(0, 3'd2, data, lat);
      check("coh_lo", data, 32'hFFFF_FFFF);
      rd_word(0, 3'd3, data, lat);
      check("coh_hi", data, 32'h0000_0000);
      rd_word(0, 3'd2, data, lat);
      rd_word(0, 3'd3, data, lat);
      check("coh_hi2", data, 32'h0000_0001);

      // clear keeps run; run=0 freezes the counter
      wr_word(0, 3'd4, 32'h2);
      rd_word(0, 3'd2, data, lat);
      check("clr_lo", data, 32'd0);
      rd_word(0, 3'd4, data, lat);
      check("clr_ctrl", data, 32'h1);
      wr_word(0, 3'd4, 32'h0);
      for (int i = 0; i < 10; i++) begin
         rd_word(0, 3'd2, data, lat);
         check("stopped", data, 32'(m_cnt[0]));
      end
      wr_word(0, 3'd4, 32'h1);

      // scratch with a single implemented word
      wr_word(0, 3'd5, 32'hDEAD_BEEF);
      wr_word(0, 3'd6, 32'hDEAD_BEEF);
      rd_word(0, 3'd5, data, lat);
      check("scr5", data, 32'hDEAD_BEEF);
      rd_word(0, 3'd6, data, lat);
      check("scr6", data, 32'd0);
      rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 3'd5; wd[0] = 32'h1234_5678;
      @(negedge clk);
      rd[0] = 1'b0; wr[0] = 1'b0;
      repeat (4) @(negedge clk);
      rd_word(0, 3'd5, data, lat);
      check("scr5_rw", data, 32'hDEAD_BEEF);
      wr_word(0, 3'd0, 32'h0);
      rd_word(0, 3'd0, data, lat);
      check("ro_id", data, SID0);
      wr_word(1, 3'd7, 32'hCAFE_F00D);
      rd_word(1, 3'd7, data, lat);
      check("scr7", data, 32'hCAFE_F00D);

      // wrap on a 33-bit counter
      deposit(1, max1);
      @(negedge clk);
      rd_word(1, 3'd4, data, lat);
      check("wrap_set", data, 32'h5);
      wr_word(1, 3'd4, 32'h5);
      rd_word(1, 3'd4, data, lat);
      check("wrap_w1c", data, 32'h1);
      // wrap and its W1C in the same cycle
      wr[1] = 1'b1; addr[1] = 3'd4; wd[1] = 32'h5;
      deposit(1, max1);
      @(negedge clk);
      wr[1] = 1'b0;
      rd_word(1, 3'd4, data, lat);
      check("wrap_same", data, 32'h5);
      wr_word(1, 3'd4, 32'h5);
      // clear overrides a wrap in the same cycle
      wr[1] = 1'b1; addr[1] = 3'd4; wd[1] = 32'h3;
      deposit(1, max1);
      @(negedge clk);
      wr[1] = 1'b0;
      rd_word(1, 3'd4, data, lat);
      check("wrap_clr", data, 32'h1);

      // reset while reads are in flight
      rd[1] = 1'b1; addr[1] = 3'd0;
      @(negedge clk);
      addr[1] = 3'd1;
      @(negedge clk);
      rst[1] = 1'b1; addr[1] = 3'd0;
      @(negedge clk);
      rst[1] = 1'b0; rd[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("flush_rdv", 32'(rdv[1]), 32'd0);
         @(negedge clk);
      end
      rd_word(1, 3'd4, data, lat);
      check("rst_ctrl", data, 32'h1);

      // random traffic on both instances
      for (int c = 0; c < 2000; c++) begin
         for (int d = 0; d < 2; d++) begin
            rst[d]  = ($urandom_range(0, 299) == 0);
            rd[d]   = 1'($urandom_range(0, 1));
            wr[d]   = ($urandom_range(0, 2) == 0);
            addr[d] = 3'($urandom_range(0, 7));
            wd[d]   = $urandom;
            if (addr[d] == 3'd4 && $urandom_range(0, 3) != 0) wd[d][0] = 1'b1;
            case ($urandom_range(0, 99))
               0: deposit(d, (64'd1 << uw(d)) - 64'($urandom_range(1, 6)));
               1: deposit(d, 64'h0000_0000_FFFF_FFFF - 64'($urandom_range(0, 4)));
               default: ;
            endcase
         end
         @(negedge clk);
      end
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
      end
      repeat (8) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sysid_regbank.md
SYSID_REGBANK -- requirements
Module: sysid_regbank

Interface
REQ-001 SHALL have parameter SYSTEM_ID, default 32'h56DC_3F2D, meaning the constant returned at word 0.
REQ-002 SHALL have parameter TIMESTAMP, default 32'h0, meaning the build time constant returned at word 1.
REQ-003 SHALL have parameter UPTIME_WIDTH, default 48, legal 33..64, meaning the uptime counter width.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal 1..4, meaning cycles from read accept to readdatavalid.
REQ-005 SHALL have parameter NUM_SCRATCH, default 2, legal 0..3, meaning the number of implemented scratch words at 5..7.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clock  in  1  sole clock, all logic on rising edge; reset  in  1  synchronous active-high reset.
REQ-007 SHALL have address  in  3  word address.
REQ-008 SHALL have read  in  1  read request, accepted every cycle (no waitrequest).
REQ-009 SHALL have write  in  1  write request, accepted every cycle.
REQ-010 SHALL have writedata  in  32  write data.
REQ-011 SHALL have readdata  out  32  read data, valid only while readdatavalid=1.
REQ-012 SHALL have readdatavalid  out  1  one-cycle strobe per accepted read.

Function
REQ-013 Word map SHALL be: 0 SYSTEM_ID (RO); 1 TIMESTAMP (RO); 2 UPTIME_LO = counter[31:0] (RO); 3 UPTIME_HI = shadow, zero-extended to 32 (RO); 4 CTRL; 5..7 scratch (RW).
REQ-014 Uptime counter SHALL increment by 1 each cycle while CTRL.run=1 and hold while run=0.
REQ-015 At all-ones the counter SHALL wrap to 0 and set sticky CTRL.wrap the same cycle.
REQ-016 An accepted read of word 2 SHALL copy counter[UPTIME_WIDTH-1:32] into the shadow in the same cycle it samples counter[31:0], so a LO-then-HI read pair is coherent.
REQ-017 The shadow SHALL change only on a word-2 read or reset.
REQ-018 CTRL SHALL be: bit0 run (RW); bit1 clear (write-1 pulse, reads 0); bit2 wrap (sticky, write-1-to-clear); bits 31:3 read 0, writes ignored.
REQ-019 A CTRL write with bit1=1 SHALL zero the counter on the next edge, overriding increment and wrap in that cycle; the shadow is not cleared.
REQ-020 Wrap set and wrap W1C in the same cycle SHALL leave wrap=1.
REQ-021 Read data SHALL be sampled in the accept cycle and presented READ_LATENCY cycles later with readdatavalid=1 for exactly one cycle.
REQ-022 Reads SHALL be fully pipelined: back-to-back reads on consecutive cycles produce consecutive readdatavalid pulses in order.
REQ-023 If read and write are both high, the read SHALL be performed and the write SHALL be dropped.
REQ-024 Writes to words 0..3, and to scratch words at index >= NUM_SCRATCH, SHALL be ignored.
REQ-025 Unimplemented scratch words SHALL read 0.
REQ-026 A write followed by a read of the same word on the next cycle SHALL return the new value.
REQ-027 readdata SHALL be 0 whenever readdatavalid=0.

Reset
REQ-028 On reset: counter=0, shadow=0, run=1, wrap=0, scratch=0, read pipeline flushed, readdatavalid=0, readdata=0 from the next edge.
REQ-029 Reads in flight when reset asserts SHALL never produce readdatavalid.
REQ-030 A read with reset high SHALL be ignored.
REQ-031 The counter SHALL first reach 1 on the first edge after reset deasserts.

Verification
REQ-032 SHALL cover ID/latency: READ_LATENCY=3, read word 0 at cycle N -> readdatavalid=1 only at N+3, readdata=SYSTEM_ID; read word 1 -> TIMESTAMP.
REQ-033 SHALL cover coherency: UPTIME_WIDTH=48, force counter 0x0000_FFFF_FFFF, read 2 then 3 -> 0xFFFF_FFFF then 0x0000_0000, even though the counter has carried.
REQ-034 SHALL cover wrap: UPTIME_WIDTH=33, run to 2^33-1 -> next cycle counter=0, CTRL reads 0x5; write CTRL=0x5 -> reads 0x1.
REQ-035 SHALL cover clear/run: write CTRL=0x2 -> counter 0 next edge, run stays 1; write CTRL=0x0 -> word 2 constant over 10 reads.
REQ-036 SHALL cover scratch: NUM_SCRATCH=1, write 0xDEADBEEF to 5 and 6 -> word 5 reads 0xDEADBEEF, word 6 reads 0; read+write word 5 together -> value unchanged.
REQ-037 SHALL cover reset mid-read: READ_LATENCY=4, reads at N, N+1, reset at N+2 -> no readdatavalid through N+6; CTRL reads 0x1 afterwards.
